// File: rtl/forward_grant_arbiter.sv
// forward_grant_arbiter
// Responder side of the forward_req / forward_resp / forward_finish handshake.
// This block arbitrates NUM_PORT requesters for one shared forward path.
// - Arbitration is round-robin, and only one grant is outstanding at a time.
// - New grants are issued only while i_fwd_window is high.
// - A grant is held until the owner pulses finish or the watchdog expires.
// All outputs are registered.
module forward_grant_arbiter #(
    parameter int NUM_PORT    = 2,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_fwd_window,
    input  logic [NUM_PORT-1:0]           i_forward_req,
    output logic [NUM_PORT-1:0]           o_forward_resp,
    input  logic [NUM_PORT-1:0]           i_forward_finish,
    output logic                          o_busy,
    output logic [$clog2(NUM_PORT)-1:0]   o_owner,
    output logic                          o_timeout,
    output logic [NUM_PORT*CNT_W-1:0]     o_grant_cnt
);

    localparam int unsigned NP   = NUM_PORT;
    localparam int          OW   = $clog2(NUM_PORT);
    localparam int          WD_W = $clog2(TIMEOUT_CYC);

    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [OW-1:0]    PORT_LAST = OW'(NUM_PORT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t              r_state;
    logic [NUM_PORT-1:0] r_resp;
    logic                r_busy;
    logic [OW-1:0]       r_owner;
    logic                r_timeout;
    logic [OW-1:0]       r_rr;
    logic [WD_W-1:0]     r_wdog;
    logic [CNT_W-1:0]    r_cnt [NUM_PORT];

    logic                w_found;
    logic [OW-1:0]       w_winner;
    logic [OW-1:0]       w_idx;

    // Winner selection: the first requesting port at or after the rr pointer, with wrap-around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            w_idx = OW'((32'(r_rr) + i) % NP);
            if (!w_found && i_forward_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Grant FSM, together with its registered outputs, rr pointer, watchdog and grant counters.
    // The watchdog is cleared on entry to GRANT and also counts the GRANT cycle.
    // As a result, the forced release pulse lands TIMEOUT_CYC cycles after the resp pulse.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_resp    <= '0;
            r_busy    <= 1'b0;
            r_owner   <= '0;
            r_timeout <= 1'b0;
            r_rr      <= '0;
            r_wdog    <= '0;
            for (int unsigned p = 0; p < NP; p++) begin
                r_cnt[p] <= '0;
            end
        end else begin
            r_resp    <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_fwd_window && w_found) begin
                        r_state          <= S_GRANT;
                        r_resp[w_winner] <= 1'b1;
                        r_busy           <= 1'b1;
                        r_owner          <= w_winner;
                        r_rr             <= (w_winner == PORT_LAST) ? '0 : w_winner + 1'b1;
                        r_wdog           <= '0;
                        if (r_cnt[w_winner] != CNT_MAX) begin
                            r_cnt[w_winner] <= r_cnt[w_winner] + 1'b1;
                        end
                    end
                end
                S_GRANT: begin
                    r_state <= S_BUSY;
                    r_wdog  <= r_wdog + 1'b1;
                end
                S_BUSY: begin
                    if (i_forward_finish[r_owner]) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_wdog == WD_LAST) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pack the per-port counters into the flat output bus, with port 0 in the LSBs.
    always_comb begin
        o_grant_cnt = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            o_grant_cnt[p*CNT_W +: CNT_W] = r_cnt[p];
        end
    end

    assign o_forward_resp = r_resp;
    assign o_busy         = r_busy;
    assign o_owner        = r_owner;
    assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_forward_grant_arbiter.sv
// tb_forward_grant_arbiter
// Scoreboard bench for forward_grant_arbiter (2 ports, 16-cycle watchdog, 4-bit counters).
// Every expected grant port is pushed when its request is driven.
// Each resp pulse pops one expected entry and is compared against it.
module tb_forward_grant_arbiter;

    localparam int NP  = 2;
    localparam int TO  = 16;
    localparam int CW  = 4;

    logic          clk;
    logic          i_rst;
    logic          i_fwd_window;
    logic [NP-1:0] i_forward_req;
    logic [NP-1:0] i_forward_finish;
    logic [NP-1:0] o_forward_resp;
    logic          o_busy;
    logic [0:0]    o_owner;
    logic          o_timeout;
    logic [NP*CW-1:0] o_grant_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_resp   = 0;
    int sb[$];

    forward_grant_arbiter #(
        .NUM_PORT    (NP),
        .TIMEOUT_CYC (TO),
        .CNT_W       (CW)
    ) u_dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_fwd_window     (i_fwd_window),
        .i_forward_req    (i_forward_req),
        .o_forward_resp   (o_forward_resp),
        .i_forward_finish (i_forward_finish),
        .o_busy           (o_busy),
        .o_owner          (o_owner),
        .o_timeout        (o_timeout),
        .o_grant_cnt      (o_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison, and report it if the observed value differs from the expected value.
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one cycle and sample 1ns after the edge; any resp pulse is scored here.
    task automatic tick();
        int e;
        @(posedge clk);
        #1;
        if (o_forward_resp !== '0) begin
            n_resp++;
            if (sb.size() == 0) begin
                check_eq("resp_unexpected", 32'(o_forward_resp), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("resp_port", 32'(o_forward_resp), 32'd1 << e);
                check_eq("resp_owner", 32'(o_owner), 32'(e));
                check_eq("resp_busy", 32'(o_busy), 32'd1);
            end
        end
    endtask

    task automatic wait_resp(input int max_cyc);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (o_forward_resp === '0 && k < max_cyc);
        check_eq("wait_resp", 32'(o_forward_resp != '0), 32'd1);
    endtask

    task automatic do_reset();
        i_rst            = 1'b0;
        i_fwd_window     = 1'b0;
        i_forward_req    = '0;
        i_forward_finish = '0;
        repeat (2) tick();
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        i_rst = 1'b1;
        tick();
    endtask

    initial begin
        i_rst            = 1'b0;
        i_fwd_window     = 1'b0;
        i_forward_req    = '0;
        i_forward_finish = '0;
        #2;
        check_eq("rst_resp", 32'(o_forward_resp), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_owner", 32'(o_owner), 32'd0);
        check_eq("rst_timeout", 32'(o_timeout), 32'd0);
        check_eq("rst_cnt", 32'(o_grant_cnt), 32'd0);

        // 1: single grant, then release on finish
        do_reset();
        repeat (5) tick();
        i_fwd_window     = 1'b1;
        i_forward_req[0] = 1'b1;
        sb.push_back(0);
        tick();
        check_eq("t1_latency", 32'(o_forward_resp), 32'd1);
        i_forward_req[0] = 1'b0;
        repeat (9) tick();
        check_eq("t1_busy_held", 32'(o_busy), 32'd1);
        i_forward_finish[0] = 1'b1;
        tick();
        i_forward_finish[0] = 1'b0;
        check_eq("t1_busy_clr", 32'(o_busy), 32'd0);
        check_eq("t1_cnt", 32'(o_grant_cnt), 32'h01);
        check_eq("t1_no_to", 32'(o_timeout), 32'd0);

        // 2: both ports requesting, so grants alternate 0,1,0,1
        do_reset();
        i_fwd_window  = 1'b1;
        i_forward_req = 2'b11;
        sb.push_back(0); sb.push_back(1); sb.push_back(0); sb.push_back(1);
        for (int g = 0; g < 4; g++) begin
            wait_resp(10);
            repeat (5) tick();
            i_forward_finish[o_owner] = 1'b1;
            tick();
            i_forward_finish = '0;
            check_eq("t2_idle_gap", 32'(o_busy), 32'd0);
        end
        i_forward_req = '0;
        tick();
        check_eq("t2_cnt", 32'(o_grant_cnt), 32'h22);
        check_eq("t2_resps", 32'(n_resp), 32'd5);

        // 3: window closed blocks grants; opening it grants on the next cycle
        do_reset();
        i_forward_req[1] = 1'b1;
        repeat (50) tick();
        check_eq("t3_blocked", 32'(o_busy), 32'd0);
        i_fwd_window = 1'b1;
        sb.push_back(1);
        tick();
        check_eq("t3_latency", 32'(o_forward_resp), 32'd2);
        i_forward_req = '0;
        i_forward_finish[1] = 1'b1;
        tick();
        i_forward_finish = '0;
        check_eq("t3_fin_in_grant", 32'(o_busy), 32'd1);
        i_forward_finish[1] = 1'b1;
        tick();
        i_forward_finish = '0;
        check_eq("t3_release", 32'(o_busy), 32'd0);

        // 4: watchdog release, then a finish on the exact expiry cycle
        do_reset();
        i_fwd_window     = 1'b1;
        i_forward_req[0] = 1'b1;
        sb.push_back(0);
        tick();
        i_forward_req = '0;
        repeat (15) tick();
        check_eq("t4_pre_to", 32'(o_timeout), 32'd0);
        check_eq("t4_pre_busy", 32'(o_busy), 32'd1);
        tick();
        check_eq("t4_to_pulse", 32'(o_timeout), 32'd1);
        check_eq("t4_to_busy", 32'(o_busy), 32'd0);
        tick();
        check_eq("t4_to_1cyc", 32'(o_timeout), 32'd0);
        i_forward_req[0] = 1'b1;
        sb.push_back(0);
        tick();
        i_forward_req = '0;
        repeat (15) tick();
        i_forward_finish[0] = 1'b1;
        tick();
        i_forward_finish = '0;
        check_eq("t4_fin_wins", 32'(o_timeout), 32'd0);
        check_eq("t4_fin_busy", 32'(o_busy), 32'd0);
        tick();
        check_eq("t4_fin_no_late_to", 32'(o_timeout), 32'd0);

        // 5: a non-owner finish is ignored; reset mid-BUSY clears everything asynchronously
        do_reset();
        i_fwd_window     = 1'b1;
        i_forward_req[0] = 1'b1;
        sb.push_back(0);
        tick();
        i_forward_req = '0;
        tick();
        i_forward_finish[1] = 1'b1;
        tick();
        i_forward_finish = '0;
        check_eq("t5_nonowner", 32'(o_busy), 32'd1);
        tick();
        check_eq("t5_still_busy", 32'(o_busy), 32'd1);
        #2;
        i_rst = 1'b0;
        #1;
        check_eq("t5_async_busy", 32'(o_busy), 32'd0);
        check_eq("t5_async_resp", 32'(o_forward_resp), 32'd0);
        check_eq("t5_async_cnt", 32'(o_grant_cnt), 32'd0);
        check_eq("t5_async_to", 32'(o_timeout), 32'd0);

        // 6: 20 grants to port 0 saturate its 4-bit counter at 15
        do_reset();
        i_fwd_window     = 1'b1;
        i_forward_req[0] = 1'b1;
        for (int g = 0; g < 20; g++) begin
            sb.push_back(0);
            wait_resp(10);
            if (g == 14) check_eq("t6_cnt15", 32'(o_grant_cnt[3:0]), 32'd15);
            tick();
            i_forward_finish[0] = 1'b1;
            tick();
            i_forward_finish = '0;
        end
        i_forward_req = '0;
        tick();
        check_eq("t6_sat", 32'(o_grant_cnt[3:0]), 32'd15);
        check_eq("t6_port1", 32'(o_grant_cnt[7:4]), 32'd0);
        check_eq("sb_final", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
